// File: rtl/elbeth_trap_control_pkg.sv
// Shared constants for the Elbeth commit-stage trap sequencer: exception codes,
// privilege levels, wb_fault bit positions and trap-control state encodings.
package elbeth_trap_control_pkg;

    localparam logic [3:0] ECODE_IF_MIS   = 4'd0;
    localparam logic [3:0] ECODE_IF_FAULT = 4'd1;
    localparam logic [3:0] ECODE_ILLEGAL  = 4'd2;
    localparam logic [3:0] ECODE_BREAK    = 4'd3;
    localparam logic [3:0] ECODE_LD_MIS   = 4'd4;
    localparam logic [3:0] ECODE_LD_FAULT = 4'd5;
    localparam logic [3:0] ECODE_ST_MIS   = 4'd6;
    localparam logic [3:0] ECODE_ST_FAULT = 4'd7;
    localparam logic [3:0] ECODE_ECALL_U  = 4'd8;
    localparam logic [3:0] ECODE_ECALL_S  = 4'd9;
    localparam logic [3:0] ECODE_ECALL_H  = 4'd10;
    localparam logic [3:0] ECODE_ECALL_M  = 4'd11;

    localparam logic [1:0] PRV_U = 2'd0;
    localparam logic [1:0] PRV_S = 2'd1;
    localparam logic [1:0] PRV_H = 2'd2;
    localparam logic [1:0] PRV_M = 2'd3;

    // Bit positions inside wb_fault
    localparam int F_ERET_REQ = 0;
    localparam int F_IF_MIS   = 1;
    localparam int F_IF_FAULT = 2;
    localparam int F_ILLEGAL  = 3;
    localparam int F_EBREAK   = 4;
    localparam int F_ECALL    = 5;
    localparam int F_LD_MIS   = 6;
    localparam int F_LD_FAULT = 7;
    localparam int F_ST_MIS   = 8;
    localparam int F_ST_FAULT = 9;

    typedef enum logic [1:0] {
        TC_IDLE  = 2'd0,
        TC_TRAP  = 2'd1,
        TC_RET   = 2'd2,
        TC_DRAIN = 2'd3
    } tc_state_t;

    function automatic logic [3:0] ecall_code(input logic [1:0] prv);
        logic [3:0] code;
        case (prv)
            PRV_U:   code = ECODE_ECALL_U;
            PRV_S:   code = ECODE_ECALL_S;
            PRV_H:   code = ECODE_ECALL_H;
            default: code = ECODE_ECALL_M;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/elbeth_trap_prio.sv
// Combinational trap priority encoder: picks the highest-priority trap source
// for the committing instruction and reports its exception code.
module elbeth_trap_prio
    import elbeth_trap_control_pkg::*;
(
    input  logic [9:0] wb_fault,
    input  logic       csr_illegal_access,
    input  logic       csr_interrupt,
    input  logic [3:0] csr_interrupt_code,
    input  logic [1:0] csr_prv,
    output logic       trap,
    output logic [3:0] code
);

    always_comb begin
        trap = 1'b1;
        code = ECODE_IF_MIS;
        if (csr_interrupt) begin
            code = csr_interrupt_code;
        end else if (wb_fault[F_IF_MIS]) begin
            code = ECODE_IF_MIS;
        end else if (wb_fault[F_IF_FAULT]) begin
            code = ECODE_IF_FAULT;
        end else if (wb_fault[F_ILLEGAL] || csr_illegal_access) begin
            code = ECODE_ILLEGAL;
        end else if (wb_fault[F_EBREAK]) begin
            code = ECODE_BREAK;
        end else if (wb_fault[F_ECALL]) begin
            code = ecall_code(csr_prv);
        end else if (wb_fault[F_LD_MIS]) begin
            code = ECODE_LD_MIS;
        end else if (wb_fault[F_LD_FAULT]) begin
            code = ECODE_LD_FAULT;
        end else if (wb_fault[F_ST_MIS]) begin
            code = ECODE_ST_MIS;
        end else if (wb_fault[F_ST_FAULT]) begin
            code = ECODE_ST_FAULT;
        end else if (wb_fault[F_ERET_REQ] && csr_prv != PRV_M) begin
            // Returning from below machine mode is an illegal instruction
            code = ECODE_ILLEGAL;
        end else begin
            trap = 1'b0;
        end
    end

endmodule

// File: rtl/elbeth_trap_control.sv
// Commit-stage trap sequencer: raises CSR trap/eret/retire strobes, then drives
// a registered redirect followed by FLUSH_CYCLES of pipeline flush.
module elbeth_trap_control
    import elbeth_trap_control_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic        wb_stall,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_mem_addr,
    input  logic [9:0]  wb_fault,
    input  logic        csr_illegal_access,
    input  logic [1:0]  csr_prv,
    input  logic        csr_interrupt,
    input  logic [3:0]  csr_interrupt_code,
    input  logic [31:0] csr_handler_pc,
    input  logic [31:0] csr_epc,
    output logic        exception,
    output logic [3:0]  exception_code,
    output logic [31:0] exception_pc,
    output logic [31:0] exception_load_addr,
    output logic        eret,
    output logic        retire,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    tc_state_t          state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic               flush_q, flush_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;

    logic               go;
    logic               trap;
    logic [3:0]         trap_code;

    elbeth_trap_prio u_prio (
        .wb_fault           (wb_fault),
        .csr_illegal_access (csr_illegal_access),
        .csr_interrupt      (csr_interrupt),
        .csr_interrupt_code (csr_interrupt_code),
        .csr_prv            (csr_prv),
        .trap               (trap),
        .code               (trap_code)
    );

    // Outside IDLE the commit slot is squashed, so every strobe is gated by go
    assign go                  = (state_q == TC_IDLE) && wb_valid && !wb_stall;
    assign exception           = go && trap;
    assign exception_code      = trap_code;
    assign exception_pc        = wb_pc;
    assign exception_load_addr = wb_mem_addr;
    assign eret                = go && !trap && wb_fault[F_ERET_REQ] && (csr_prv == PRV_M);
    assign retire              = go && !trap && !wb_fault[F_ERET_REQ];

    always_comb begin
        state_d          = state_q;
        counter_d        = counter_q;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        case (state_q)
            TC_IDLE: begin
                if (exception) begin
                    state_d = TC_TRAP;
                end else if (eret) begin
                    state_d = TC_RET;
                end
            end
            // The CSR file has taken the trap/eret by now, so its vectors are current
            TC_TRAP, TC_RET: begin
                flush_d          = 1'b1;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = (state_q == TC_TRAP) ? csr_handler_pc : csr_epc;
                counter_d        = CNT_W'(FLUSH_CYCLES);
                state_d          = TC_DRAIN;
            end
            TC_DRAIN: begin
                flush_d   = 1'b1;
                counter_d = counter_q - CNT_W'(1);
                if (counter_q == CNT_W'(1)) begin
                    state_d = TC_IDLE;
                end
            end
            default: state_d = TC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= TC_IDLE;
            counter_q        <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            counter_q        <= counter_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_elbeth_trap_control.sv
// Self-checking bench for elbeth_trap_control: per-cycle expected outputs are
// queued as stimulus is driven and compared on the falling edge.
module tb_elbeth_trap_control;

    localparam logic [31:0] HANDLER = 32'h0000_01C0;
    localparam logic [31:0] EPC     = 32'h0000_0088;

    localparam logic [9:0] F_ERET  = 10'h001;
    localparam logic [9:0] F_IFMIS = 10'h002;
    localparam logic [9:0] F_IFFLT = 10'h004;
    localparam logic [9:0] F_ILL   = 10'h008;
    localparam logic [9:0] F_EBRK  = 10'h010;
    localparam logic [9:0] F_ECALL = 10'h020;
    localparam logic [9:0] F_LDMIS = 10'h040;
    localparam logic [9:0] F_LDFLT = 10'h080;
    localparam logic [9:0] F_STMIS = 10'h100;
    localparam logic [9:0] F_STFLT = 10'h200;

    localparam logic [1:0] P_U = 2'd0;
    localparam logic [1:0] P_S = 2'd1;
    localparam logic [1:0] P_M = 2'd3;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic        wb_stall;
    logic [31:0] wb_pc;
    logic [31:0] wb_mem_addr;
    logic [9:0]  wb_fault;
    logic        csr_illegal_access;
    logic [1:0]  csr_prv;
    logic        csr_interrupt;
    logic [3:0]  csr_interrupt_code;
    logic [31:0] csr_handler_pc;
    logic [31:0] csr_epc;
    logic        exception;
    logic [3:0]  exception_code;
    logic [31:0] exception_pc;
    logic [31:0] exception_load_addr;
    logic        eret;
    logic        retire;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  dbg_state;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    elbeth_trap_control #(.FLUSH_CYCLES(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .wb_valid            (wb_valid),
        .wb_stall            (wb_stall),
        .wb_pc               (wb_pc),
        .wb_mem_addr         (wb_mem_addr),
        .wb_fault            (wb_fault),
        .csr_illegal_access  (csr_illegal_access),
        .csr_prv             (csr_prv),
        .csr_interrupt       (csr_interrupt),
        .csr_interrupt_code  (csr_interrupt_code),
        .csr_handler_pc      (csr_handler_pc),
        .csr_epc             (csr_epc),
        .exception           (exception),
        .exception_code      (exception_code),
        .exception_pc        (exception_pc),
        .exception_load_addr (exception_load_addr),
        .eret                (eret),
        .retire              (retire),
        .flush               (flush),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .dbg_state           (dbg_state)
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic        stall;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [9:0]  f;
        logic        ill;
        logic        intr;
        logic [3:0]  icode;
        logic [1:0]  prv;
        logic [40:0] exp;
    } step_t;

    // Scoreboard
    logic [40:0] exp_q[$];
    logic [40:0] got, want;
    int          n_tests  = 0;
    int          n_failed = 0;
    logic [31:0] rpc_model = 32'h0;

    // {exception, code, eret, retire, flush, redirect_valid, redirect_pc}
    function automatic logic [40:0] ev(input logic exc, input logic [3:0] code, input logic er,
                                       input logic rt, input logic fl, input logic rv,
                                       input logic [31:0] rpc);
        return {exc, code, er, rt, fl, rv, rpc};
    endfunction

    function automatic logic [40:0] obs();
        return {exception, (exception ? exception_code : 4'd0), eret, retire,
                flush, redirect_valid, redirect_pc};
    endfunction

    function automatic step_t mk(input logic v, input logic [9:0] f, input logic [1:0] prv,
                                 input logic [40:0] e);
        step_t s;
        s.rst = 1'b0; s.v = v; s.stall = 1'b0; s.pc = 32'h100; s.addr = 32'h203;
        s.f = f; s.ill = 1'b0; s.intr = 1'b0; s.icode = 4'd0; s.prv = prv; s.exp = e;
        return s;
    endfunction

    // Cycles after a trap/eret: c1 = TRAP/RET, c2..c3 = DRAIN, c4 = IDLE with flush still registered
    function automatic logic [40:0] tail_exp(input int c, input logic [31:0] prev,
                                             input logic [31:0] tgt);
        if (c == 1) return ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, prev);
        if (c == 2) return ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, tgt);
        return ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, tgt);
    endfunction

    function automatic step_t tail_step(input int c, input logic [31:0] prev,
                                        input logic [31:0] tgt);
        step_t s;
        s = mk(c <= 3, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3)),
               tail_exp(c, prev, tgt));
        s.intr  = 1'($urandom_range(0, 1));
        s.icode = 4'($urandom_range(0, 15));
        s.ill   = 1'($urandom_range(0, 1));
        return s;
    endfunction

    // Driver
    task automatic drive(input step_t s);
        @(posedge clk);
        #1;
        rst                = s.rst;
        wb_valid           = s.v;
        wb_stall           = s.stall;
        wb_pc              = s.pc;
        wb_mem_addr        = s.addr;
        wb_fault           = s.f;
        csr_illegal_access = s.ill;
        csr_interrupt      = s.intr;
        csr_interrupt_code = s.icode;
        csr_prv            = s.prv;
        exp_q.push_back(s.exp);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; wb_valid = 1'b0; wb_stall = 1'b0; wb_fault = '0;
        csr_interrupt = 1'b0; csr_illegal_access = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rpc_model = 32'h0;
    endtask

    task automatic test_reset();
        step_t s;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            s = mk(1'b0, F_LDMIS, P_M, ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
            drive(s);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_failed++;
                $display("FAIL reset[%0d]: got %h required %h", i, got, want);
            end
        end
        n_tests++;
        if (dbg_state !== 2'd0) begin
            n_failed++;
            $display("FAIL reset_state: got %0d required 0", dbg_state);
        end
    endtask

    task automatic test_retire();
        step_t s;
        for (int i = 0; i < 3; i++) begin
            s = mk(1'b1, 10'h0, P_U, ev(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, rpc_model));
            s.pc = 32'h200 + 32'(4 * i);
            drive(s);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_failed++;
                $display("FAIL retire[%0d]: got %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_ld_mis();
        step_t s;
        s = mk(1'b1, F_LDMIS, P_M, ev(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, rpc_model));
        drive(s);
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); n_tests++;
        if (got !== want) begin
            n_failed++;
            $display("FAIL ld_mis_trap: got %h required %h", got, want);
        end
        n_tests++;
        if (exception_pc !== 32'h100 || exception_load_addr !== 32'h203) begin
            n_failed++;
            $display("FAIL ld_mis_addr: got pc %h addr %h required 100 203",
                     exception_pc, exception_load_addr);
        end
        for (int c = 1; c <= 4; c++) begin
            drive(tail_step(c, rpc_model, HANDLER));
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_failed++;
                $display("FAIL ld_mis_tail[%0d]: got %h required %h", c, got, want);
            end
        end
        rpc_model = HANDLER;
        s = mk(1'b1, 10'h0, P_M, ev(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, rpc_model));
        drive(s);
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); n_tests++;
        if (got !== want || dbg_state !== 2'd0) begin
            n_failed++;
            $display("FAIL ld_mis_back_idle: got %h st %0d required %h st 0", got, dbg_state, want);
        end
    endtask

    task automatic test_interrupt();
        step_t s;
        s = mk(1'b1, F_ILL, P_M, ev(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, rpc_model));
        s.pc = 32'h44; s.intr = 1'b1; s.icode = 4'd7; s.ill = 1'b1;
        drive(s);
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); n_tests++;
        if (got !== want || exception_pc !== 32'h44) begin
            n_failed++;
            $display("FAIL interrupt: got %h pc %h required %h pc 44", got, exception_pc, want);
        end
        for (int c = 1; c <= 4; c++) begin
            drive(tail_step(c, rpc_model, HANDLER));
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_failed++;
                $display("FAIL interrupt_tail[%0d]: got %h required %h", c, got, want);
            end
        end
        rpc_model = HANDLER;
    endtask

    task automatic test_eret();
        step_t s;
        logic [1:0]  prv_t [2] = '{P_M, P_U};
        logic [31:0] tgt_t [2] = '{EPC, HANDLER};
        for (int k = 0; k < 2; k++) begin
            if (k == 0) s = mk(1'b1, F_ERET, prv_t[k], ev(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, rpc_model));
            else        s = mk(1'b1, F_ERET, prv_t[k], ev(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, rpc_model));
            drive(s);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_failed++;
                $display("FAIL eret_prv%0d: got %h required %h", prv_t[k], got, want);
            end
            for (int c = 1; c <= 4; c++) begin
                drive(tail_step(c, rpc_model, tgt_t[k]));
                @(negedge clk);
                got = obs(); want = exp_q.pop_front(); n_tests++;
                if (got !== want) begin
                    n_failed++;
                    $display("FAIL eret_tail%0d[%0d]: got %h required %h", k, c, got, want);
                end
            end
            rpc_model = tgt_t[k];
        end
    endtask

    task automatic test_priority();
        step_t s;
        logic [9:0] pf [12] = '{F_ECALL, F_ECALL, F_ECALL, F_IFMIS | F_LDMIS | F_ECALL,
                                F_IFFLT | F_ILL | F_STFLT, F_EBRK, F_EBRK | F_ECALL | F_LDMIS,
                                F_LDFLT | F_STMIS, F_STMIS | F_STFLT, F_STFLT | F_ERET,
                                F_LDMIS | F_ERET, F_ILL};
        logic [1:0] pp [12] = '{P_U, P_S, P_M, P_U, P_M, P_M, P_M, P_M, P_M, P_M, P_U, P_M};
        logic       pi [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        logic [3:0] pc [12] = '{4'd8, 4'd9, 4'd11, 4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7,
                                4'd4, 4'd2};
        for (int k = 0; k < 12; k++) begin
            s = mk(1'b1, pf[k], pp[k], ev(1'b1, pc[k], 1'b0, 1'b0, 1'b0, 1'b0, rpc_model));
            s.ill = pi[k];
            drive(s);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_failed++;
                $display("FAIL prio[%0d]: got %h required %h", k, got, want);
            end
            for (int c = 1; c <= 4; c++) begin
                drive(tail_step(c, rpc_model, HANDLER));
                @(negedge clk);
                got = obs(); want = exp_q.pop_front(); n_tests++;
                if (got !== want) begin
                    n_failed++;
                    $display("FAIL prio_tail%0d[%0d]: got %h required %h", k, c, got, want);
                end
            end
            rpc_model = HANDLER;
        end
    endtask

    task automatic test_stall();
        step_t s;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) s = mk(1'b1, F_LDFLT, P_M, ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, rpc_model));
            else       s = mk(1'b1, F_LDFLT, P_M, ev(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, rpc_model));
            s.stall = (i < 3);
            drive(s);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_tests++;
            if (got !== want || dbg_state !== 2'd0) begin
                n_failed++;
                $display("FAIL stall[%0d]: got %h st %0d required %h st 0", i, got, dbg_state, want);
            end
        end
        for (int c = 1; c <= 4; c++) begin
            drive(tail_step(c, rpc_model, HANDLER));
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_failed++;
                $display("FAIL stall_tail[%0d]: got %h required %h", c, got, want);
            end
        end
        rpc_model = HANDLER;
    endtask

    task automatic test_rst_in_drain();
        step_t s;
        for (int c = 0; c <= 3; c++) begin
            if (c == 0)      s = mk(1'b1, F_LDMIS, P_M, ev(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, rpc_model));
            else if (c < 3)  s = tail_step(c, rpc_model, HANDLER);
            else             s = mk(1'b1, 10'h0, P_M, ev(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
            s.rst = (c == 2);
            drive(s);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_failed++;
                $display("FAIL rst_drain[%0d]: got %h required %h", c, got, want);
            end
        end
        n_tests++;
        if (dbg_state !== 2'd0) begin
            n_failed++;
            $display("FAIL rst_drain_state: got %0d required 0", dbg_state);
        end
        rpc_model = 32'h0;
    endtask

    task automatic test_random_retire();
        step_t s;
        logic  v, st;
        for (int i = 0; i < 20; i++) begin
            v  = 1'($urandom_range(0, 1));
            st = 1'($urandom_range(0, 1));
            s = mk(v, 10'h0, 2'($urandom_range(0, 3)),
                   ev(1'b0, 4'd0, 1'b0, v & ~st, 1'b0, 1'b0, rpc_model));
            s.stall = st;
            drive(s);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_failed++;
                $display("FAIL rand_retire[%0d]: got %h required %h", i, got, want);
            end
        end
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_stall = 1'b0; wb_pc = '0; wb_mem_addr = '0;
        wb_fault = '0; csr_illegal_access = 1'b0; csr_prv = P_M; csr_interrupt = 1'b0;
        csr_interrupt_code = '0; csr_handler_pc = HANDLER; csr_epc = EPC;
        test_reset();
        test_retire();
        test_ld_mis();
        test_interrupt();
        test_eret();
        test_priority();
        test_stall();
        test_rst_in_drain();
        test_random_retire();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
